bcd_game_counter: RTL and testbench

Parametrised successor to the SymCounter game top: a DIGITS-wide BCD up/down counter driven by three raw push-buttons, with per-button synchronisation and debouncing, wrap or saturate modes, and time-multiplexed active-low seven-segment drive. It sits directly behind the board pins (`btnS`/`btnU`/`btnD`, `seg`/`an`) and also exports the BCD value and an overflow pulse to the game logic.

---
 rtl/sym_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/bcd_game_counter.sv | 224 ++++++++++++++++++++++
 tb/tb_bcd_game_counter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sym_pkg
//  Description : Shared types, constants and the seven-segment encoder used
//                by the BCD game counter and its button front-end.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package sym_pkg;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // All segments off (active-low drive)
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off, non-decimal codes blank
    function automatic logic [7:0] seg7_encode(input bcd_t digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser, counter debouncer and registered
//                one-cycle press pulse for a raw asynchronous push-button.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module btn_debounce
    import sym_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btnRaw,
    output logic o_level,
    output logic o_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_levelDly;
    logic               r_press;

    // Bring the raw pin into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[0], i_btnRaw};
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Press pulse on the rising edge of the accepted level only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_levelDly <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_levelDly <= r_level;
            r_press    <= r_level & ~r_levelDly;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/bcd_game_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_game_counter
//  Description : DIGITS-wide BCD up/down counter driven by three debounced
//                push-buttons, with wrap/saturate modes, overflow pulse and
//                multiplexed active-low seven-segment drive.
//                Optional auto-repeat: define BCD_GAME_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module bcd_game_counter
    import sym_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SCAN_CYC     = 100_000,
    parameter int WRAP         = 1,
    parameter int REPEAT_DLY   = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000
) (
    input  logic                  Clk100M,
    input  logic                  Rst_n,
    input  logic                  btnS,
    input  logic                  btnU,
    input  logic                  btnD,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic                  ovf
);

    localparam int c_VAL_W = 4 * DIGITS;
    localparam int c_PRE_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_CYC - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_AN_ONE   = DIGITS'(1);

    logic w_pressS, w_pressU, w_pressD;
    logic w_levelS, w_levelU, w_levelD;
    logic w_repU, w_repD;
    logic w_stepU, w_stepD;

    logic [c_VAL_W-1:0] r_value;
    logic               r_ovf;
    logic [c_VAL_W-1:0] w_incVal, w_decVal;
    logic               w_incCarry, w_decBorrow;

    logic [c_PRE_W-1:0] r_pre;
    logic [c_IDX_W-1:0] r_idx;
    logic [7:0]         r_seg;
    logic [DIGITS-1:0]  r_an;
    bcd_t               w_scanDigit;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbS (
        .clk(Clk100M), .rst_n(Rst_n), .i_btnRaw(btnS), .o_level(w_levelS), .o_press(w_pressS)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbU (
        .clk(Clk100M), .rst_n(Rst_n), .i_btnRaw(btnU), .o_level(w_levelU), .o_press(w_pressU)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbD (
        .clk(Clk100M), .rst_n(Rst_n), .i_btnRaw(btnD), .o_level(w_levelD), .o_press(w_pressD)
    );

`ifdef BCD_GAME_AUTOREPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
    localparam int c_RPT_W   = (c_RPT_MAX > 1) ? $clog2(c_RPT_MAX) : 1;
    localparam logic [c_RPT_W-1:0] c_DLY_LAST = c_RPT_W'(REPEAT_DLY - 1);
    localparam logic [c_RPT_W-1:0] c_CYC_LAST = c_RPT_W'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RUN   = 2'd2
    } rptState_t;

    rptState_t          r_rptState, w_rptStateNext;
    logic [c_RPT_W-1:0] r_rptCnt, w_rptCntNext;
    logic               r_rptUp, w_rptUpNext;
    logic               w_holdOne;
    logic               w_unusedLevel;

    assign w_unusedLevel = w_levelS;

    // Auto-repeat state register
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rptState <= RPT_IDLE;
            r_rptCnt   <= '0;
            r_rptUp    <= 1'b0;
        end else begin
            r_rptState <= w_rptStateNext;
            r_rptCnt   <= w_rptCntNext;
            r_rptUp    <= w_rptUpNext;
        end
    end

    // Arm on a lone press, time the hold, emit extra steps while one button stays held
    always_comb begin
        w_rptStateNext = r_rptState;
        w_rptCntNext   = r_rptCnt;
        w_rptUpNext    = r_rptUp;
        w_repU         = 1'b0;
        w_repD         = 1'b0;
        w_holdOne      = r_rptUp ? (w_levelU & ~w_levelD) : (w_levelD & ~w_levelU);
        if (w_pressS) begin
            w_rptStateNext = RPT_IDLE;
            w_rptCntNext   = '0;
        end else if (w_pressU && !w_pressD && !w_levelD) begin
            w_rptStateNext = RPT_DELAY;
            w_rptCntNext   = '0;
            w_rptUpNext    = 1'b1;
        end else if (w_pressD && !w_pressU && !w_levelU) begin
            w_rptStateNext = RPT_DELAY;
            w_rptCntNext   = '0;
            w_rptUpNext    = 1'b0;
        end else if (r_rptState != RPT_IDLE) begin
            if (!w_holdOne) begin
                w_rptStateNext = RPT_IDLE;
                w_rptCntNext   = '0;
            end else if (r_rptCnt == ((r_rptState == RPT_DELAY) ? c_DLY_LAST : c_CYC_LAST)) begin
                w_repU         = r_rptUp;
                w_repD         = ~r_rptUp;
                w_rptStateNext = RPT_RUN;
                w_rptCntNext   = '0;
            end else begin
                w_rptCntNext   = r_rptCnt + 1'b1;
            end
        end
    end
`else
    // No repeat hardware: the held levels and repeat timing go unused
    localparam int c_unusedRepeat = REPEAT_DLY + REPEAT_CYC;
    logic w_unusedLevel;

    assign w_unusedLevel = ^{w_levelS, w_levelU, w_levelD};
    assign w_repU        = 1'b0;
    assign w_repD        = 1'b0;
`endif

    assign w_stepU = w_pressU | w_repU;
    assign w_stepD = w_pressD | w_repD;

    // BCD ripple increment/decrement; carry/borrow out flags a range end
    always_comb begin
        logic carry;
        logic borrow;
        carry    = 1'b1;
        borrow   = 1'b1;
        w_incVal = r_value;
        w_decVal = r_value;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (r_value[4*d +: 4] == 4'd9) begin
                    w_incVal[4*d +: 4] = 4'd0;
                end else begin
                    w_incVal[4*d +: 4] = r_value[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (r_value[4*d +: 4] == 4'd0) begin
                    w_decVal[4*d +: 4] = 4'd9;
                end else begin
                    w_decVal[4*d +: 4] = r_value[4*d +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        w_incCarry  = carry;
        w_decBorrow = borrow;
    end

    // Count register: clear wins, opposing steps cancel, range ends wrap or hold
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_pressS) begin
                r_value <= '0;
            end else if (w_stepU && !w_stepD) begin
                r_ovf <= w_incCarry;
                if (!w_incCarry || (WRAP != 0)) r_value <= w_incVal;
            end else if (w_stepD && !w_stepU) begin
                r_ovf <= w_decBorrow;
                if (!w_decBorrow || (WRAP != 0)) r_value <= w_decVal;
            end
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_scanDigit = r_value[{r_idx, 2'b00} +: 4];

    // Segment and anode registered together so they switch on the same edge
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= seg7_encode(w_scanDigit);
            r_an  <= ~(c_AN_ONE << r_idx);
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign value = r_value;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bcd_game_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bcd_game_counter
//  Description : Self-checking bench for bcd_game_counter; a wrapping and a
//                saturating instance share the buttons and are compared with
//                an integer-valued reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_game_counter;

    localparam int DIGITS       = 4;
    localparam int DEBOUNCE_CYC = 4;
    localparam int SCAN_CYC     = 2;
    localparam int REPEAT_DLY   = 20;
    localparam int REPEAT_CYC   = 5;
    localparam int MAXV         = 9999;
    localparam int GAP          = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, btnS, btnU, btnD;
    logic [7:0]  segW, segS;
    logic [3:0]  anW, anS;
    logic [15:0] valueW, valueS;
    logic        ovfW, ovfS;

    bcd_game_counter #(
        .DIGITS(DIGITS), .DEBOUNCE_CYC(DEBOUNCE_CYC), .SCAN_CYC(SCAN_CYC), .WRAP(1),
        .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC)
    ) dutW (
        .Clk100M(clk), .Rst_n(rst_n), .btnS(btnS), .btnU(btnU), .btnD(btnD),
        .seg(segW), .an(anW), .value(valueW), .ovf(ovfW)
    );

    bcd_game_counter #(
        .DIGITS(DIGITS), .DEBOUNCE_CYC(DEBOUNCE_CYC), .SCAN_CYC(SCAN_CYC), .WRAP(0),
        .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC)
    ) dutS (
        .Clk100M(clk), .Rst_n(rst_n), .btnS(btnS), .btnU(btnU), .btnD(btnD),
        .seg(segS), .an(anS), .value(valueS), .ovf(ovfS)
    );

    int nChecks = 0;
    int nFails  = 0;
    int modelW  = 0, modelS  = 0;
    int expOvfW = 0, expOvfS = 0;
    int ovfCntW = 0, ovfCntS = 0;
    int cyc;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycles since reset release, for the expected scan position
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Count cycles with ovf high on each instance
    always @(negedge clk) begin
        if (ovfW === 1'b1) ovfCntW++;
        if (ovfS === 1'b1) ovfCntS++;
    end

    function automatic logic [31:0] toBcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int digitOf(input int v, input int pos);
        for (int i = 0; i < pos; i++) v = v / 10;
        return v % 10;
    endfunction

    function automatic logic [7:0] segCode(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a button combination for 'hold' cycles, then release and settle
    task automatic pressOp(input logic s, input logic u, input logic d, input int hold);
        btnS = s; btnU = u; btnD = d;
        idle(hold);
        btnS = 1'b0; btnU = 1'b0; btnD = 1'b0;
        idle(GAP);
    endtask

    task automatic modelStep(input int dir);
        if (dir > 0) begin
            if (modelW == MAXV) begin modelW = 0; expOvfW++; end else modelW++;
            if (modelS == MAXV) expOvfS++; else modelS++;
        end else begin
            if (modelW == 0) begin modelW = MAXV; expOvfW++; end else modelW--;
            if (modelS == 0) expOvfS++; else modelS--;
        end
    endtask

    task automatic checkScan(input string tag);
        int idx;
        idx = ((cyc - 1) / SCAN_CYC) % DIGITS;
        checkEq({tag, "_an"},  anW,  32'((~(1 << idx)) & 4'hF));
        checkEq({tag, "_seg"}, segW, segCode(digitOf(modelW, idx)));
    endtask

    task automatic checkState(input string tag);
        checkEq({tag, "_valW"}, valueW, toBcd(modelW));
        checkEq({tag, "_valS"}, valueS, toBcd(modelS));
        checkEq({tag, "_ovfW"}, ovfCntW, expOvfW);
        checkEq({tag, "_ovfS"}, ovfCntS, expOvfS);
        checkScan(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] anSeq [4];
        int firstChange;
        int op, hold;

        anSeq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst_n = 1'b0; btnS = 1'b0; btnU = 1'b0; btnD = 1'b0;
        idle(3);

        // Reset state
        checkEq("rst_value", valueW, 0);
        checkEq("rst_ovf",   ovfW,   0);
        checkEq("rst_seg",   segW,   8'hFF);
        checkEq("rst_an",    anW,    4'hF);
        checkEq("rst_valueS", valueS, 0);

        // Anode walk after release
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkEq("walk_an",  anW,  anSeq[i / 2]);
            checkEq("walk_seg", segW, 8'hC0);
        end
        checkEq("walk_value", valueW, 0);

        // Press latency: value steps exactly 7 edges after the first sampling edge
        firstChange = -1;
        btnU = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (firstChange < 0 && valueW != 16'h0000) firstChange = k;
        end
        btnU = 1'b0;
        idle(GAP);
        checkEq("latency_edge", firstChange, 7);
        modelStep(1);
        checkState("single_press");

        // A 2-cycle pulse is rejected as a glitch
        pressOp(1'b0, 1'b1, 1'b0, 2);
        checkState("glitch2");

        // Range ends: wrap instance goes 0->9999->0, saturating instance holds at 0
        pressOp(1'b1, 1'b0, 1'b0, 5);
        modelW = 0; modelS = 0;
        checkState("clear");
        pressOp(1'b0, 1'b0, 1'b1, 5);
        modelStep(-1);
        checkState("dec_at_zero");
        pressOp(1'b0, 1'b1, 1'b0, 5);
        modelStep(1);
        checkState("inc_at_max");

        // Randomized button traffic
        for (int n = 0; n < 60; n++) begin
            op   = int'($urandom_range(0, 9));
            hold = int'($urandom_range(DEBOUNCE_CYC + 1, DEBOUNCE_CYC + 6));
            if (op <= 3) begin
                pressOp(1'b0, 1'b1, 1'b0, hold);
                modelStep(1);
            end else if (op <= 6) begin
                pressOp(1'b0, 1'b0, 1'b1, hold);
                modelStep(-1);
            end else if (op == 7) begin
                pressOp(1'b1, 1'b0, 1'b0, hold);
                modelW = 0; modelS = 0;
            end else if (op == 8) begin
                pressOp(1'b0, 1'b1, 1'b1, hold);
            end else if ($urandom_range(0, 1) == 0) begin
                pressOp(1'b0, 1'b1, 1'b0, int'($urandom_range(1, DEBOUNCE_CYC - 1)));
            end else begin
                pressOp(1'b1, 1'b1, 1'b0, hold);
                modelW = 0; modelS = 0;
            end
            checkState("random");
        end

        // Carry chain: 0999 + 1
        pressOp(1'b1, 1'b0, 1'b0, 5);
        modelW = 0; modelS = 0;
        for (int n = 0; n < 999; n++) begin
            pressOp(1'b0, 1'b1, 1'b0, 5);
            modelStep(1);
        end
        checkState("preset_0999");
        pressOp(1'b0, 1'b1, 1'b0, 5);
        modelStep(1);
        checkState("carry_1000");

        // Clear overrides a simultaneous increment, no ovf
        pressOp(1'b1, 1'b0, 1'b0, 5);
        modelW = 0; modelS = 0;
        for (int n = 0; n < 42; n++) begin
            pressOp(1'b0, 1'b1, 1'b0, 5);
            modelStep(1);
        end
        checkState("preset_0042");
        pressOp(1'b1, 1'b1, 1'b0, 6);
        modelW = 0; modelS = 0;
        checkState("clear_over_up");

`ifdef BCD_GAME_AUTOREPEAT_EN
        // Auto-repeat: step at press, then +20, +25, +30, +35 while held
        btnU = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checkEq("repeat_val", valueW,
                    32'((k >= 7) + (k >= 27) + (k >= 32) + (k >= 37) + (k >= 42)));
            if (k == 39) btnU = 1'b0;
        end
        modelW = 5; modelS = 5;
        idle(GAP);
        checkState("repeat_done");
`endif

        // Asynchronous reset in the middle of a hold
        pressOp(1'b0, 1'b1, 1'b0, 5);
        modelStep(1);
        btnU = 1'b1;
        idle(9);
        modelStep(1);
        checkEq("prereset_val", valueW, toBcd(modelW));
        #2 rst_n = 1'b0;
        #1;
        checkEq("midrst_valW", valueW, 0);
        checkEq("midrst_valS", valueS, 0);
        checkEq("midrst_an",   anW,    4'hF);
        checkEq("midrst_seg",  segW,   8'hFF);
        btnU = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(GAP + 6);
        checkEq("postrst_valW", valueW, 0);
        checkEq("postrst_valS", valueS, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
